fetch_stage: RTL and testbench

- Front-end producer of the pc2/instr2 pair consumed by the decode stage.
- Generates sequential PCs and issues requests on the instruction-memory req/gnt/rvalid interface.
- Buffers returned instructions in a small FIFO and presents one instruction per cycle when decode is not stalled.
- Handles branch/jump redirects by flushing buffered and in-flight wrong-path fetches.

---
 rtl/core_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-stage types and constants
package core_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO of fetch entries with flush
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 din,
    input  logic                         pop,
    output fetch_entry_t                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full buffer is accepted only when a pop frees a slot on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - sequential instruction fetch with credit-limited buffering and redirect flush
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = core_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc2,
    output logic [31:0] instr2
);
    import core_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t  state;
    logic [31:0]   pc_f;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] outstanding_next;
    logic [CW:0]   credit_used;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] tag_count;
    logic          buf_empty, buf_full, tag_empty, tag_full;
    logic          buf_pop, buf_push, issue, resp_ok;
    fetch_entry_t  buf_head, buf_din, tag_head, tag_din;
    logic          unused_sig;

    always_comb begin
        buf_pop          = !stall && !buf_empty && !redirect;
        // A pop this cycle frees a slot, which keeps back-to-back fetch at L=1.
        credit_used      = {1'b0, outstanding} + {1'b0, buf_count} - (CW+1)'(buf_pop);
        imem_req         = (state == RUN) && !redirect && (credit_used < (CW+1)'(FIFO_DEPTH));
        imem_addr        = pc_f;
        issue            = imem_req && imem_gnt;
        resp_ok          = imem_rvalid && (outstanding != '0);
        outstanding_next = outstanding + CW'(issue) - CW'(resp_ok);
        buf_push         = resp_ok && (discard == '0);
        buf_din          = '{pc: tag_head.pc, instr: imem_rdata};
        tag_din          = '{pc: pc_f, instr: 32'h0};
        pc2              = (buf_empty || redirect) ? 32'h0 : buf_head.pc;
        instr2           = (buf_empty || redirect) ? NOP_INSTR : buf_head.instr;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= BOOT;
            pc_f        <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect) begin
                pc_f    <= {target[31:2], 2'b00};
                discard <= outstanding_next;
                state   <= (outstanding_next != '0) ? DRAIN : RUN;
            end else begin
                if (issue) pc_f <= pc_f + 32'd4;
                if (resp_ok && discard != '0) discard <= discard - 1'b1;
                case (state)
                    BOOT:    state <= RUN;
                    DRAIN:   if (discard == '0 || (resp_ok && discard == CW'(1))) state <= RUN;
                    default: state <= RUN;
                endcase
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_buf (
        .clk(clk), .rst_n(nrst), .flush(redirect),
        .push(buf_push), .din(buf_din), .pop(buf_pop),
        .dout(buf_head), .count(buf_count), .empty(buf_empty), .full(buf_full)
    );

    // Tag queue is never flushed: wrong-path responses still need their tag popped.
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_tag (
        .clk(clk), .rst_n(nrst), .flush(1'b0),
        .push(issue), .din(tag_din), .pop(resp_ok),
        .dout(tag_head), .count(tag_count), .empty(tag_empty), .full(tag_full)
    );

    assign unused_sig = ^{tag_head.instr, tag_count, tag_empty, tag_full, buf_full, target[1:0]};

    rvalid_without_fetch: assert property (@(posedge clk) disable iff (!nrst)
        !(imem_rvalid && outstanding == '0))
        else $warning("fetch_stage: imem_rvalid with no fetch outstanding, response ignored");

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage
module tb_fetch_stage;
    import core_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          due;
        logic [31:0] salt;
    } pend_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc2;
    logic [31:0] instr2;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           lat = 1;
    int           n_out = 0;
    logic [31:0]  salt = '0;
    pend_t        pend[$];
    fetch_entry_t exp_q[$];

    fetch_stage dut (
        .clk(clk), .nrst(nrst), .stall(stall), .redirect(redirect), .target(target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc2(pc2), .instr2(instr2)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_path(input logic [31:0] start, input logic [31:0] s);
        exp_q.delete();
        for (int i = 0; i < 48; i++) begin
            exp_q.push_back('{pc: start + 32'(4 * i), instr: (start + 32'(4 * i)) ^ s});
        end
    endtask

    // One cycle: memory model and output scoreboard at the falling edge, then advance.
    task automatic tick_req(input int req_exp, input logic [31:0] addr_exp);
        fetch_entry_t e;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].addr ^ pend[0].salt;
            void'(pend.pop_front());
        end
        if (imem_req && imem_gnt) pend.push_back('{addr: imem_addr, due: cyc + lat, salt: salt});
        if (req_exp >= 0) check("imem_req", {31'b0, imem_req}, 32'(req_exp));
        if (req_exp == 1) check("imem_addr", imem_addr, addr_exp);
        if (redirect) begin
            check("redirect_instr2", instr2, NOP_INSTR);
            check("redirect_pc2", pc2, 32'h0);
        end else if (instr2 !== NOP_INSTR) begin
            check("exp_available", {31'b0, exp_q.size() > 0}, 32'h1);
            if (exp_q.size() > 0) begin
                if (stall) begin
                    check("stall_hold_pc2", pc2, exp_q[0].pc);
                    check("stall_hold_instr2", instr2, exp_q[0].instr);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc2", pc2, e.pc);
                    check("out_instr2", instr2, e.instr);
                    n_out++;
                end
            end
        end else begin
            check("bubble_pc2", pc2, 32'h0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_req(-1, 32'h0);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        imem_gnt = 1'b1;
        imem_rvalid = 1'b0;
        salt = '0;
        pend.delete();
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_pc2", pc2, 32'h0);
        check("reset_instr2", instr2, NOP_INSTR);
        check("reset_req", {31'b0, imem_req}, 32'h0);
        nrst = 1'b1;
        n_out = 0;
    endtask

    initial begin
        // Streaming at L=1, then a three-cycle stall while pc2=0x8.
        do_reset();
        lat = 1;
        set_path(32'h0, 32'h0);
        tick_req(0, 32'h0);
        tick_req(1, 32'h0);
        tick_req(1, 32'h4);
        tick();
        tick();
        check("lat1_count", 32'(n_out), 32'd2);
        stall = 1'b1;
        repeat (3) tick_req(0, 32'h0);
        stall = 1'b0;
        tick_req(1, 32'h10);
        tick();
        tick();
        check("stall_release_count", 32'(n_out), 32'd5);

        // Redirect with two fetches in flight at L=3.
        do_reset();
        lat = 3;
        set_path(32'h100, 32'h0);
        tick();
        tick_req(1, 32'h0);
        tick_req(1, 32'h4);
        redirect = 1'b1;
        target = 32'h100;
        tick_req(0, 32'h0);
        redirect = 1'b0;
        tick_req(0, 32'h0);
        tick_req(0, 32'h0);
        tick_req(1, 32'h100);
        repeat (6) tick();
        check("drain_count", 32'(n_out), 32'd2);

        // Redirect and stall together, unaligned target.
        do_reset();
        lat = 1;
        set_path(32'h0, 32'h0);
        repeat (5) tick();
        stall = 1'b1;
        redirect = 1'b1;
        target = 32'h203;
        set_path(32'h200, 32'h0);
        tick_req(0, 32'h0);
        stall = 1'b0;
        redirect = 1'b0;
        n_out = 0;
        tick_req(1, 32'h200);
        tick_req(1, 32'h204);
        tick();
        tick();
        check("redir_stall_count", 32'(n_out), 32'd2);

        // Grant withheld for four cycles at 0x40.
        do_reset();
        lat = 1;
        tick_req(0, 32'h0);
        redirect = 1'b1;
        target = 32'h40;
        set_path(32'h40, 32'h0);
        tick_req(0, 32'h0);
        redirect = 1'b0;
        imem_gnt = 1'b0;
        repeat (4) tick_req(1, 32'h40);
        imem_gnt = 1'b1;
        tick_req(1, 32'h40);
        tick_req(1, 32'h44);
        tick();
        tick();
        check("gnt_wait_count", 32'(n_out), 32'd2);

        // Reset pulse with two fetches in flight; their responses arrive after release.
        do_reset();
        lat = 3;
        set_path(32'h0, 32'h0);
        tick();
        tick_req(1, 32'h0);
        tick_req(1, 32'h4);
        nrst = 1'b0;
        #1;
        check("midreset_pc2", pc2, 32'h0);
        check("midreset_instr2", instr2, NOP_INSTR);
        check("midreset_req", {31'b0, imem_req}, 32'h0);
        tick();
        salt = 32'h5A00_0000;
        set_path(32'h0, salt);
        nrst = 1'b1;
        n_out = 0;
        tick_req(0, 32'h0);
        tick_req(1, 32'h0);
        repeat (6) tick();
        check("post_reset_count", 32'(n_out), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
